// File: rtl/mem_write_buffer_if.sv
// Cache-side and memory-side bus bundle for the write-back buffer.
// slave is the buffer's view; master is the cache plus memory view.
interface mem_write_buffer_if #(
    parameter int AW = 28
);
    logic           c_read;
    logic           c_write;
    logic [AW-1:0]  c_addr;
    logic [127:0]   c_wdata;
    logic [127:0]   c_rdata;
    logic           c_ready;
    logic           mem_read;
    logic           mem_write;
    logic [AW-1:0]  mem_addr;
    logic [127:0]   mem_wdata;
    logic [127:0]   mem_rdata;
    logic           mem_ready;

    modport slave (
        input  c_read, c_write, c_addr, c_wdata,
        input  mem_rdata, mem_ready,
        output c_rdata, c_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output c_read, c_write, c_addr, c_wdata,
        output mem_rdata, mem_ready,
        input  c_rdata, c_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Write-back buffer between a cache and slow memory.
// Queues dirty blocks, forwards reads from pending entries, drains when idle.
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28
) (
    input logic              clk,
    input logic              rst_n,
    mem_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] addr_q [DEPTH];
    logic [127:0]  data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] idx;
    logic [PW:0]   count;
    logic          full;
    logic          rd_req;
    logic          push;
    logic          pop;
    logic          hit;
    logic          hit_ack;
    logic          miss;
    logic          drain;
    logic          rd_done;
    logic [127:0]  hit_data;

    // Requests are held through their c_ready cycle, so ignore them then.
    assign full   = (count == (PW+1)'(DEPTH));
    assign rd_req = bus.c_read && !bus.c_ready;
    assign push   = bus.c_write && !bus.c_read && !bus.c_ready && !full;

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((PW+1)'(k) < count && addr_q[idx] == bus.c_addr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        hit_ack   = 1'b0;
        miss      = 1'b0;
        drain     = 1'b0;
        rd_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    if (hit) begin
                        hit_ack = 1'b1;
                    end else begin
                        miss      = 1'b1;
                        state_nxt = RD;
                    end
                end else if (!bus.c_read && count != '0) begin
                    drain     = 1'b1;
                    state_nxt = WR;
                end
            end
            RD: begin
                if (bus.mem_ready) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR: begin
                if (bus.mem_ready) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= bus.c_addr;
            data_q[tail] <= bus.c_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            bus.c_ready   <= 1'b0;
            bus.c_rdata   <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state       <= state_nxt;
            bus.c_ready <= push | hit_ack | rd_done;
            count       <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            if (hit_ack) begin
                bus.c_rdata <= hit_data;
            end else if (rd_done) begin
                bus.c_rdata <= bus.mem_rdata;
            end
            if (miss) begin
                bus.mem_read <= 1'b1;
                bus.mem_addr <= bus.c_addr;
            end
            if (rd_done) bus.mem_read <= 1'b0;
            if (drain) begin
                bus.mem_write <= 1'b1;
                bus.mem_addr  <= addr_q[head];
                bus.mem_wdata <= data_q[head];
            end
            if (pop) bus.mem_write <= 1'b0;
        end
    end
endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of 128-bit write-back entries (power of 2, at least 2).
REQ-002 SHALL have parameter AW, default 28: block address width (address bits [31:4]).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port c_read, input, 1: cache block read request, held until c_ready.
REQ-006 SHALL have port c_write, input, 1: cache block write-back request, held until c_ready.
REQ-007 SHALL have port c_addr, input, AW: cache request block address.
REQ-008 SHALL have port c_wdata, input, 128: cache write-back data.
REQ-009 SHALL have port c_rdata, output, 128: registered read data to cache.
REQ-010 SHALL have port c_ready, output, 1: registered one-cycle completion pulse to cache.
REQ-011 SHALL have port mem_read, output, 1: registered slow-memory read request.
REQ-012 SHALL have port mem_write, output, 1: registered slow-memory write request.
REQ-013 SHALL have port mem_addr, output, AW: registered slow-memory block address.
REQ-014 SHALL have port mem_wdata, output, 128: registered slow-memory write data.
REQ-015 SHALL have port mem_rdata, input, 128: slow-memory read data, valid with mem_ready.
REQ-016 SHALL have port mem_ready, input, 1: slow-memory completion pulse; mem_read/mem_write/mem_addr/mem_wdata stay stable until it is sampled high.

Function
REQ-017 SHALL hold a FIFO of DEPTH {addr, data} entries with a count of 0..DEPTH; full means count==DEPTH, empty means count==0.
REQ-018 SHALL sample a request only while c_ready is low, so a request held through its c_ready cycle is never taken twice.
REQ-019 SHALL accept a write (c_write, not full, c_read low) in any FSM state: push {c_addr, c_wdata} at the tail, then drive c_ready high in the next cycle.
REQ-020 SHALL hold c_write pending with c_ready low while full, and accept it in the cycle after count drops below DEPTH.
REQ-021 SHALL use a three-state FSM: IDLE, RD, WR.
REQ-022 In IDLE on c_read, SHALL compare c_addr against all valid entries; on a hit it SHALL load c_rdata from the newest matching entry, pulse c_ready in the next cycle and stay in IDLE.
REQ-023 In IDLE on a c_read miss, SHALL enter RD and drive mem_read=1 with mem_addr=c_addr from the next cycle.
REQ-024 In RD on mem_ready, SHALL load c_rdata from mem_rdata, drop mem_read, pulse c_ready in the next cycle, and return to IDLE.
REQ-025 In IDLE with no c_read and count>0, SHALL enter WR and drive mem_write=1 with the head entry's addr/data from the next cycle.
REQ-026 In WR on mem_ready, SHALL pop the head, drop mem_write, and return to IDLE.
REQ-027 SHALL give a pending c_read priority over draining in IDLE, and SHALL not abort a WR already started.
REQ-028 On a simultaneous push and pop, SHALL leave count unchanged; head and tail pointers wrap modulo DEPTH.
REQ-029 SHALL service c_read first when c_read and c_write are both high, leaving the write pending.
REQ-030 SHALL never drive mem_read and mem_write high together.

Reset
REQ-031 On rst_n low, SHALL immediately set FSM=IDLE, count=0, pointers=0, and c_ready, c_rdata, mem_read, mem_write, mem_addr, mem_wdata all to 0, discarding buffered and in-flight data, including a request mid-transfer.

Verification
REQ-032 Write addr 0x10, data A with memory stalled -> c_ready 1 cycle later, count=1; then mem_write with mem_addr=0x10, mem_wdata=A until mem_ready, count=0.
REQ-033 Four writes with mem_ready held low -> four c_ready pulses, count=4; a fifth write stays pending until the first mem_ready, then gets c_ready in the next cycle.
REQ-034 Write 0x20=A, then 0x20=B, then read 0x20 before drain -> c_rdata=B, c_ready 1 cycle after the read, no mem_read issued.
REQ-035 Read miss 0x30 with 2 entries buffered -> mem_read with mem_addr=0x30 precedes any mem_write; on mem_ready with mem_rdata=C -> c_rdata=C and c_ready next cycle.
REQ-036 Deassert rst_n during WR with count=3 -> mem_write=0, count=0, c_ready=0 immediately; after release, no memory request until a new c_read or c_write.
